// File: rtl/bus_rr.sv
// Round-robin multi-host / multi-device bus with one transaction in flight.
// Adds device grant, variable response latency, decode errors and a watchdog.
module bus_rr #(
  parameter int NrHosts       = 2,
  parameter int NrDevices     = 2,
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int TimeoutCycles = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NrHosts-1:0]        host_req_i,
  output logic [NrHosts-1:0]        host_gnt_o,
  input  logic [AddressWidth-1:0]   host_addr_i [NrHosts],
  input  logic [NrHosts-1:0]        host_we_i,
  input  logic [DataWidth/8-1:0]    host_be_i [NrHosts],
  input  logic [DataWidth-1:0]      host_wdata_i [NrHosts],
  output logic [NrHosts-1:0]        host_rvalid_o,
  output logic [DataWidth-1:0]      host_rdata_o [NrHosts],
  output logic [NrHosts-1:0]        host_err_o,
  output logic [NrDevices-1:0]      device_req_o,
  input  logic [NrDevices-1:0]      device_gnt_i,
  output logic [AddressWidth-1:0]   device_addr_o [NrDevices],
  output logic [NrDevices-1:0]      device_we_o,
  output logic [DataWidth/8-1:0]    device_be_o [NrDevices],
  output logic [DataWidth-1:0]      device_wdata_o [NrDevices],
  input  logic [NrDevices-1:0]      device_rvalid_i,
  input  logic [DataWidth-1:0]      device_rdata_i [NrDevices],
  input  logic [NrDevices-1:0]      device_err_i,
  input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
  input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices]
);

  localparam int HW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int DVW = (NrDevices > 1) ? $clog2(NrDevices) : 1;
  localparam int CW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RESP,
    ERR_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [HW-1:0]    rr_ptr;
  logic [HW-1:0]    host_q;
  logic [DVW-1:0]   dev_q;
  logic [CW-1:0]    cnt;

  logic             sel_found;
  logic [HW-1:0]    sel_host;
  logic             dec_hit;
  logic [DVW-1:0]   dec_dev;
  logic             timeout;
  logic [HW-1:0]    rr_next;

  // Pick the first requesting host at or after rr_ptr, wrapping around.
  always_comb begin
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_host  = '0;
    for (int i = 0; i < NrHosts; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NrHosts) idx = idx - NrHosts;
      if (!sel_found && host_req_i[idx]) begin
        sel_found = 1'b1;
        sel_host  = HW'(idx);
      end
    end
  end

  // Address decode of the selected host; the lowest matching device wins.
  always_comb begin
    dec_hit = 1'b0;
    dec_dev = '0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if ((host_addr_i[sel_host] & cfg_device_addr_mask[d])
          == cfg_device_addr_base[d]) begin
        dec_hit = 1'b1;
        dec_dev = DVW'(d);
      end
    end
  end

  assign timeout = (TimeoutCycles > 0) &&
                   (cnt == CW'(TimeoutCycles - 1));
  assign rr_next = (sel_host == HW'(NrHosts - 1)) ?
                   '0 : sel_host + HW'(1);

  // Next state and all bus outputs; everything is held low while in reset.
  always_comb begin
    state_d       = state_q;
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    host_err_o    = '0;
    device_req_o  = '0;
    device_we_o   = '0;
    for (int h = 0; h < NrHosts; h++) host_rdata_o[h] = '0;
    for (int d = 0; d < NrDevices; d++) begin
      device_addr_o[d]  = '0;
      device_be_o[d]    = '0;
      device_wdata_o[d] = '0;
    end
    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          if (sel_found) begin
            if (dec_hit) begin
              device_req_o[dec_dev]   = 1'b1;
              device_addr_o[dec_dev]  = host_addr_i[sel_host];
              device_we_o[dec_dev]    = host_we_i[sel_host];
              device_be_o[dec_dev]    = host_be_i[sel_host];
              device_wdata_o[dec_dev] = host_wdata_i[sel_host];
              host_gnt_o[sel_host]    = device_gnt_i[dec_dev];
              if (device_gnt_i[dec_dev]) state_d = WAIT_RESP;
            end else begin
              host_gnt_o[sel_host] = 1'b1;
              state_d              = ERR_RESP;
            end
          end
        end
        WAIT_RESP: begin
          if (device_rvalid_i[dev_q]) begin
            host_rvalid_o[host_q] = 1'b1;
            host_rdata_o[host_q]  = device_rdata_i[dev_q];
            host_err_o[host_q]    = device_err_i[dev_q];
            state_d               = IDLE;
          end else if (timeout) begin
            host_rvalid_o[host_q] = 1'b1;
            host_err_o[host_q]    = 1'b1;
            state_d               = IDLE;
          end
        end
        ERR_RESP: begin
          host_rvalid_o[host_q] = 1'b1;
          host_err_o[host_q]    = 1'b1;
          state_d               = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, round-robin pointer, latched host/device and saturating watchdog.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_ptr  <= '0;
      host_q  <= '0;
      dev_q   <= '0;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      if (|host_gnt_o) begin
        rr_ptr <= rr_next;
        host_q <= sel_host;
        dev_q  <= dec_dev;
        cnt    <= '0;
      end else if (state_q == WAIT_RESP && cnt != {CW{1'b1}}) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_bus_rr.sv
// Scoreboard bench for bus_rr: expected responses are queued at issue time
// and matched against host responses by a negedge monitor.
module tb_bus_rr;
  localparam int NH = 2;
  localparam int ND = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  typedef struct {
    int          host;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [NH-1:0]   host_req, host_gnt, host_we, host_rvalid, host_err;
  logic [AW-1:0]   host_addr [NH];
  logic [DW/8-1:0] host_be [NH];
  logic [DW-1:0]   host_wdata [NH];
  logic [DW-1:0]   host_rdata [NH];
  logic [ND-1:0]   dev_req, dev_gnt, dev_we, dev_rvalid, dev_err;
  logic [AW-1:0]   dev_addr [ND];
  logic [DW/8-1:0] dev_be [ND];
  logic [DW-1:0]   dev_wdata [ND];
  logic [DW-1:0]   dev_rdata [ND];
  logic [AW-1:0]   base [ND];
  logic [AW-1:0]   mask [ND];

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ng [NH];

  always #5 clk = ~clk;

  bus_rr #(
    .NrHosts(NH), .NrDevices(ND), .DataWidth(DW),
    .AddressWidth(AW), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .host_req_i(host_req), .host_gnt_o(host_gnt),
    .host_addr_i(host_addr), .host_we_i(host_we),
    .host_be_i(host_be), .host_wdata_i(host_wdata),
    .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata),
    .host_err_o(host_err),
    .device_req_o(dev_req), .device_gnt_i(dev_gnt),
    .device_addr_o(dev_addr), .device_we_o(dev_we),
    .device_be_o(dev_be), .device_wdata_o(dev_wdata),
    .device_rvalid_i(dev_rvalid), .device_rdata_i(dev_rdata),
    .device_err_i(dev_err),
    .cfg_device_addr_base(base), .cfg_device_addr_mask(mask)
  );

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  // Match every host response against the oldest expected entry.
  always @(negedge clk) begin : mon
    exp_t e;
    for (int h = 0; h < NH; h++) begin
      if (host_rvalid[h]) begin
        if (q.size() == 0) begin
          check("unexp_rvalid", 64'(host_rvalid[h]), 64'(0));
        end else begin
          e = q.pop_front();
          check("rsp_host", 64'(h), 64'(e.host));
          check("rsp_data", 64'(host_rdata[h]), 64'(e.data));
          check("rsp_err", 64'(host_err[h]), 64'(e.err));
        end
      end
    end
  end

  initial begin
    rst        = 1'b1;
    host_req   = '0;
    host_we    = '0;
    dev_gnt    = '1;
    dev_rvalid = '0;
    dev_err    = '0;
    for (int i = 0; i < NH; i++) begin
      host_addr[i]  = '0;
      host_be[i]    = '1;
      host_wdata[i] = '0;
      ng[i]         = 0;
    end
    for (int i = 0; i < ND; i++) dev_rdata[i] = '0;
    base[0] = 32'h0000_0000; mask[0] = 32'hFFFF_0000;
    base[1] = 32'h0001_0000; mask[1] = 32'hFFFF_0000;

    host_req = 2'b11;
    host_addr[0] = 32'h10;
    host_addr[1] = 32'h20;
    smp();
    check("rst_gnt", 64'(host_gnt), 64'(0));
    check("rst_dreq", 64'(dev_req), 64'(0));
    check("rst_rvalid", 64'(host_rvalid), 64'(0));
    cyc();
    rst = 1'b0;
    host_req = '0;

    // single read to device 1, response three cycles after grant
    cyc();
    host_req = 2'b01;
    host_addr[0] = 32'h0001_0004;
    host_we[0] = 1'b0;
    q.push_back('{0, 32'hDEADBEEF, 1'b0});
    smp();
    check("t1_dreq", 64'(dev_req), 64'(2'b10));
    check("t1_gnt", 64'(host_gnt), 64'(2'b01));
    check("t1_daddr", 64'(dev_addr[1]), 64'(32'h0001_0004));
    check("t1_daddr0", 64'(dev_addr[0]), 64'(0));
    cyc();
    host_req = '0;
    dev_rvalid = 2'b01;
    dev_rdata[0] = 32'h5555_5555;
    smp();
    check("t1_wait_dreq", 64'(dev_req), 64'(0));
    check("t1_wrongdev", 64'(host_rvalid), 64'(0));
    cyc();
    dev_rvalid = '0;
    smp();
    check("t1_wait2", 64'(host_rvalid), 64'(0));
    cyc();
    dev_rvalid = 2'b10;
    dev_rdata[1] = 32'hDEADBEEF;
    smp();
    check("t1_rvalid", 64'(host_rvalid), 64'(2'b01));
    cyc();
    dev_rvalid = '0;

    // round robin with an instantly responding device
    do_reset();
    host_addr[0] = 32'h0000_0010;
    host_addr[1] = 32'h0000_0020;
    for (int i = 0; i < 8; i++) begin
      cyc();
      dev_rvalid = '0;
      host_req = 2'b11;
      q.push_back('{i % 2, 32'hA000_0000 + i, 1'b0});
      smp();
      check("t2_gnt", 64'(host_gnt), 64'(1) << (i % 2));
      ng[0] += int'(host_gnt[0]);
      ng[1] += int'(host_gnt[1]);
      cyc();
      dev_rvalid = 2'b01;
      dev_rdata[0] = 32'hA000_0000 + i;
      smp();
      check("t2_wait_gnt", 64'(host_gnt), 64'(0));
    end
    cyc();
    dev_rvalid = '0;
    host_req = '0;
    check("t2_ng0", 64'(ng[0]), 64'(4));
    check("t2_ng1", 64'(ng[1]), 64'(4));

    // unmapped write gets a decode error
    cyc();
    host_req = 2'b10;
    host_addr[1] = 32'hF000_0000;
    host_we[1] = 1'b1;
    host_wdata[1] = 32'h1111_2222;
    q.push_back('{1, 32'h0, 1'b1});
    smp();
    check("t3_gnt", 64'(host_gnt), 64'(2'b10));
    check("t3_dreq", 64'(dev_req), 64'(0));
    cyc();
    host_req = '0;
    host_we[1] = 1'b0;
    smp();
    check("t3_dreq2", 64'(dev_req), 64'(0));
    check("t3_rvalid", 64'(host_rvalid), 64'(2'b10));

    // device never answers: watchdog fires four cycles after grant
    cyc();
    host_req = 2'b01;
    host_addr[0] = 32'h0000_0100;
    q.push_back('{0, 32'h0, 1'b1});
    smp();
    check("t4_gnt", 64'(host_gnt), 64'(2'b01));
    check("t4_dreq", 64'(dev_req), 64'(2'b01));
    for (int k = 1; k <= 3; k++) begin
      cyc();
      host_req = '0;
      smp();
      check("t4_wait", 64'(host_rvalid), 64'(0));
    end
    cyc();
    smp();
    check("t4_timeout", 64'(host_rvalid), 64'(2'b01));
    cyc();
    smp();
    cyc();
    dev_rvalid = 2'b01;
    dev_rdata[0] = 32'h0000_1234;
    smp();
    check("t4_late", 64'(host_rvalid), 64'(0));
    cyc();
    dev_rvalid = '0;

    // device withholds grant for three cycles
    cyc();
    dev_gnt = 2'b01;
    host_req = 2'b01;
    host_addr[0] = 32'h0001_0008;
    host_we[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      smp();
      check("t5_hold_dreq", 64'(dev_req), 64'(2'b10));
      check("t5_hold_gnt", 64'(host_gnt), 64'(0));
      cyc();
    end
    dev_gnt = '1;
    q.push_back('{0, 32'hCAFEF00D, 1'b1});
    smp();
    check("t5_gnt", 64'(host_gnt), 64'(2'b01));
    check("t5_dreq", 64'(dev_req), 64'(2'b10));
    cyc();
    host_req = '0;
    host_we[0] = 1'b0;
    dev_rvalid = 2'b10;
    dev_rdata[1] = 32'hCAFEF00D;
    dev_err = 2'b10;
    smp();
    check("t5_rvalid", 64'(host_rvalid), 64'(2'b01));
    check("t5_single", 64'(dev_req), 64'(0));
    cyc();
    dev_rvalid = '0;
    dev_err = '0;

    // reset while waiting drops the transaction and the pointer
    cyc();
    host_req = 2'b01;
    host_addr[0] = 32'h0000_0200;
    smp();
    check("t6_gnt", 64'(host_gnt), 64'(2'b01));
    cyc();
    host_req = '0;
    smp();
    cyc();
    rst = 1'b1;
    dev_rvalid = 2'b01;
    dev_rdata[0] = 32'h0000_0077;
    smp();
    check("t6_rst_rvalid", 64'(host_rvalid), 64'(0));
    check("t6_rst_gnt", 64'(host_gnt), 64'(0));
    check("t6_rst_dreq", 64'(dev_req), 64'(0));
    cyc();
    rst = 1'b0;
    smp();
    check("t6_post_rvalid", 64'(host_rvalid), 64'(0));
    cyc();
    dev_rvalid = '0;
    host_req = 2'b11;
    host_addr[0] = 32'h0000_0300;
    host_addr[1] = 32'h0001_0300;
    q.push_back('{0, 32'h0000_4242, 1'b0});
    smp();
    check("t6_rr_restart", 64'(host_gnt), 64'(2'b01));
    cyc();
    host_req = '0;
    dev_rvalid = 2'b01;
    dev_rdata[0] = 32'h0000_4242;
    smp();
    cyc();
    dev_rvalid = '0;
    cyc();
    smp();
    check("q_empty", 64'(q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
